// File: rtl/vc_fifo_param_if.sv
// Bundles the FIFO's request/data/status signals between a producer-consumer
// agent (master) and the FIFO itself (slave).
//
// Request semantics: wr_enable and rd_enable are one-cycle requests sampled on
// each rising clk edge. A read is taken only when the FIFO is not empty. A write
// is taken when the FIFO is not full, or when a read is taken on the same edge.
// A request that is not taken is dropped and raises the sticky error flag.
// A taken read presents its word on data_out, with valid_out high, one cycle later.
interface vc_fifo_param_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_enable;
    logic                  rd_enable;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] umbral_af;
    logic [ADDR_WIDTH-1:0] umbral_ae;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  error;
    logic [ADDR_WIDTH:0]   fill_level;

    modport master (
        output wr_enable, rd_enable, data_in, umbral_af, umbral_ae,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               error, fill_level
    );

    modport slave (
        input  wr_enable, rd_enable, data_in, umbral_af, umbral_ae,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               error, fill_level
    );
endinterface

// File: rtl/vc_fifo_param.sv
// Synchronous FIFO with 2**ADDR_WIDTH entries, a registered read port, and
// programmable almost-full/almost-empty thresholds. Dropped requests set a
// sticky error flag. The error flag is cleared by the asynchronous reset or
// by the synchronous init clear.
module vc_fifo_param #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           init,
    vc_fifo_param_if.slave bus
);
    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   fill_level;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  error;

    logic full;
    logic empty;
    logic rd_ok;
    logic wr_ok;
    logic req_rejected;

    // The status flags are decoded only from occupancy, so they can never
    // disagree with fill_level.
    assign full  = (fill_level == DEPTH_L);
    assign empty = (fill_level == '0);

    // A read is taken only when data is present, with no bypass from a
    // same-cycle write. A write into a full FIFO is still taken when a read
    // frees a slot on the same edge.
    assign rd_ok        = bus.rd_enable & ~empty;
    assign wr_ok        = bus.wr_enable & (~full | rd_ok);
    assign req_rejected = (bus.wr_enable & ~wr_ok) | (bus.rd_enable & ~rd_ok);

    // Storage is never cleared. Stale words are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (init && wr_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers, occupancy, registered read port and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            error      <= 1'b0;
        end else if (!init) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                data_out  <= mem[rd_ptr];
                valid_out <= 1'b1;
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
            end else begin
                data_out  <= '0;
                valid_out <= 1'b0;
            end
            case ({wr_ok, rd_ok})
                2'b10:   fill_level <= fill_level + (ADDR_WIDTH + 1)'(1);
                2'b01:   fill_level <= fill_level - (ADDR_WIDTH + 1)'(1);
                default: fill_level <= fill_level;
            endcase
            if (req_rejected) begin
                error <= 1'b1;
            end
        end
    end

    // Thresholds are widened by one bit so that DEPTH - umbral_af cannot wrap.
    assign bus.almost_full  = (fill_level >= (DEPTH_L - {1'b0, bus.umbral_af}));
    assign bus.almost_empty = (fill_level <= {1'b0, bus.umbral_ae});

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.fill_level = fill_level;
    assign bus.data_out   = data_out;
    assign bus.valid_out  = valid_out;
    assign bus.error      = error;
endmodule
